// File: rtl/aes_pkg.sv
// Shared AES definitions: controller state encoding, round-count constants and
// the GF(2^8) byte and column helpers used by the inverse round datapath.
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } ctrl_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] t;
        logic [7:0] r;
        t = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine transform, then invert in GF(2^8).
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        for (int i = 0; i < 8; i++) begin
            a[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return gf_inv(a ^ 8'h05);
    endfunction

    // Byte i (FIPS order, i = row + 4*col) lives at [127-8i -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8 * (r + 4 * c) -: 8] = s[127 - 8 * (r + 4 * ((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        {s0, s1, s2, s3} = col;
        return {gmul14(s0) ^ gmul11(s1) ^ gmul13(s2) ^ gmul9(s3),
                gmul9(s0)  ^ gmul14(s1) ^ gmul11(s2) ^ gmul13(s3),
                gmul13(s0) ^ gmul9(s1)  ^ gmul14(s2) ^ gmul11(s3),
                gmul11(s0) ^ gmul13(s1) ^ gmul9(s2)  ^ gmul14(s3)};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES decryption round: InvShiftRows, InvSubBytes,
// AddRoundKey and, except on the final round, InvMixColumns.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] state_out
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    assign shifted = inv_shift_rows(state_in);

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        assign subbed[127 - 8 * i -: 8] = inv_sbox(shifted[127 - 8 * i -: 8]);
    end

    assign keyed = subbed ^ rk;

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127 - 32 * c -: 32] = inv_mix_column(keyed[127 - 32 * c -: 32]);
    end

    assign state_out = last ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer: one decryption round per clock,
// valid/ready on ciphertext input and plaintext output.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    localparam logic [3:0] NR_IDX      = 4'(NR);
    localparam logic [3:0] FIRST_ROUND = 4'(NR - 1);

    ctrl_state_t  fsm, fsm_nxt;
    logic [3:0]   round, round_nxt;
    logic [127:0] state_reg, state_reg_nxt;
    logic [127:0] round_out;

    aes_inv_round u_round (
        .state_in  (state_reg),
        .rk        (rk),
        .last      (round == 4'd0),
        .state_out (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            round     <= 4'd0;
            state_reg <= '0;
        end else begin
            fsm       <= fsm_nxt;
            round     <= round_nxt;
            state_reg <= state_reg_nxt;
        end
    end

    // A load (IDLE accept or DONE back-to-back) applies the initial AddRoundKey with key NR.
    always_comb begin
        fsm_nxt       = fsm;
        round_nxt     = round;
        state_reg_nxt = state_reg;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        rk_idx        = NR_IDX;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_reg_nxt = ct ^ rk;
                    round_nxt     = FIRST_ROUND;
                    fsm_nxt       = ROUND;
                end
            end
            ROUND: begin
                busy          = 1'b1;
                rk_idx        = round;
                state_reg_nxt = round_out;
                if (round == 4'd0) begin
                    fsm_nxt = DONE;
                end else begin
                    round_nxt = round - 4'd1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_reg_nxt = ct ^ rk;
                        round_nxt     = FIRST_ROUND;
                        fsm_nxt       = ROUND;
                    end else begin
                        fsm_nxt = IDLE;
                    end
                end
            end
            default: fsm_nxt = IDLE;
        endcase
        // Abort keeps the datapath contents; only the sequencing is unwound.
        if (flush) begin
            fsm_nxt       = IDLE;
            round_nxt     = 4'd0;
            state_reg_nxt = state_reg;
        end
    end

    assign pt = state_reg;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl using FIPS-197 C.1 and C.3 vectors,
// with an independently expanded key store feeding rk from rk_idx.
module tb_aes_inv_cipher_ctrl;

    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] LOAD1 = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt;
    logic         busy;

    logic         in_valid_b;
    logic         in_ready_b;
    logic [3:0]   rk_idx_b;
    logic [127:0] rk_b;
    logic         out_valid_b;
    logic [127:0] pt_b;
    logic         busy_b;

    logic [127:0] ks128 [0:15];
    logic [127:0] ks256 [0:15];
    logic [31:0]  words [0:59];

    int total;
    int bad;

    aes_inv_cipher_ctrl #(.NR(10)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt),
        .busy      (busy)
    );

    aes_inv_cipher_ctrl #(.NR(14)) u_dut256 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .ct        (ct),
        .rk_idx    (rk_idx_b),
        .rk        (rk_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .pt        (pt_b),
        .busy      (busy_b)
    );

    assign rk   = ks128[rk_idx];
    assign rk_b = ks256[rk_idx_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] tb_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = tb_xtime(t);
        end
        return p;
    endfunction

    // Forward S-box for the key schedule: GF inverse followed by the affine map.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] a;
        logic [7:0] b;
        t = x;
        a = 8'h01;
        for (int k = 1; k < 8; k++) begin
            t = tb_mul(t, t);
            a = tb_mul(a, t);
        end
        for (int i = 0; i < 8; i++) begin
            b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8];
        end
        return b ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] temp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) words[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            temp = words[i - 1];
            if (i % nk == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = tb_xtime(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            words[i] = words[i - nk] ^ temp;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Accepts ct from IDLE and returns cycles from the accept cycle to the first out_valid cycle.
    task automatic run_block(output int cycles);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        if (rk_idx !== 4'd10) begin bad++; $display("[TB] FAIL reset_rk_idx: got %0d want 10", rk_idx); end
        if (pt !== 128'h0) begin bad++; $display("[TB] FAIL reset_pt: got %h want 0", pt); end
    endtask

    task automatic test_fips128();
        ct = CT128;
        in_valid = 1'b1;
        #1;
        total++;
        if (rk_idx !== 4'd10) begin bad++; $display("[TB] FAIL accept_rk_idx: got %0d want 10", rk_idx); end
        tick();
        in_valid = 1'b0;
        total++;
        if (pt !== LOAD1) begin bad++; $display("[TB] FAIL load_state: got %h want %h", pt, LOAD1); end
        for (int k = 9; k >= 0; k--) begin
            total += 3;
            if (rk_idx !== 4'(k)) begin bad++; $display("[TB] FAIL round_rk_idx: got %0d want %0d", rk_idx, k); end
            if (busy !== 1'b1) begin bad++; $display("[TB] FAIL round_busy: got %b want 1 (round %0d)", busy, k); end
            if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL round_out_valid: got %b want 0 (round %0d)", out_valid, k); end
            tick();
        end
        total += 3;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL c1_out_valid: got %b want 1", out_valid); end
        if (pt !== PT) begin bad++; $display("[TB] FAIL c1_pt: got %h want %h", pt, PT); end
        if (rk_idx !== 4'd10) begin bad++; $display("[TB] FAIL done_rk_idx: got %0d want 10", rk_idx); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total += 4;
            if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_out_valid: got %b want 1", out_valid); end
            if (pt !== PT) begin bad++; $display("[TB] FAIL bp_pt: got %h want %h", pt, PT); end
            if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); end
            if (busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_busy: got %b want 0", busy); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_in_ready: got %b want 1", in_ready); end
        tick();
        out_ready = 1'b0;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_after_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_after_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        ct = CT128;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            tick();
            exp_v = (c % 11 == 0);
            total += 2;
            if (out_valid !== exp_v) begin bad++; $display("[TB] FAIL b2b_out_valid: got %b want %b (cycle %0d)", out_valid, exp_v, c); end
            if (busy !== !exp_v) begin bad++; $display("[TB] FAIL b2b_busy: got %b want %b (cycle %0d)", busy, !exp_v, c); end
            if (exp_v) begin
                total += 2;
                if (pt !== PT) begin bad++; $display("[TB] FAIL b2b_pt: got %h want %h (cycle %0d)", pt, PT, c); end
                if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready: got %b want 1 (cycle %0d)", in_ready, c); end
            end
            if (c == 33) in_valid = 1'b0;
        end
        tick();
        out_ready = 1'b0;
        total += 2;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end_out_valid: got %b want 0", out_valid); end
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_end_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_flush();
        logic seen;
        int   cycles;
        ct = CT128;
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_idle_accept: busy got %b want 0", busy); end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (rk_idx !== 4'd5) begin bad++; $display("[TB] FAIL flush_pre_rk_idx: got %0d want 5", rk_idx); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total += 4;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_in_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_out_valid: got %b want 0", out_valid); end
        if (rk_idx !== 4'd10) begin bad++; $display("[TB] FAIL flush_rk_idx: got %0d want 10", rk_idx); end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen = seen | out_valid;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("[TB] FAIL flush_no_output: got %b want 0", seen); end
        run_block(cycles);
        total += 2;
        if (cycles !== 11) begin bad++; $display("[TB] FAIL flush_next_latency: got %0d want 11", cycles); end
        if (pt !== PT) begin bad++; $display("[TB] FAIL flush_next_pt: got %h want %h", pt, PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cycles;
        ct = CT128;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total += 4;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_round_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_round_busy: got %b want 0", busy); end
        if (rk_idx !== 4'd10) begin bad++; $display("[TB] FAIL rst_round_rk_idx: got %0d want 10", rk_idx); end
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_round_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        run_block(cycles);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_done_reach: got %b want 1", out_valid); end
        rst = 1'b1;
        tick();
        total += 5;
        if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_done_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_done_busy: got %b want 0", busy); end
        if (rk_idx !== 4'd10) begin bad++; $display("[TB] FAIL rst_done_rk_idx: got %0d want 10", rk_idx); end
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_done_in_ready: got %b want 1", in_ready); end
        if (pt !== 128'h0) begin bad++; $display("[TB] FAIL rst_done_pt: got %h want 0", pt); end
        rst = 1'b0;
    endtask

    task automatic test_nr14();
        int cycles;
        ct = CT256;
        in_valid_b = 1'b1;
        #1;
        total++;
        if (rk_idx_b !== 4'd14) begin bad++; $display("[TB] FAIL nr14_accept_rk_idx: got %0d want 14", rk_idx_b); end
        tick();
        in_valid_b = 1'b0;
        total++;
        if (rk_idx_b !== 4'd13) begin bad++; $display("[TB] FAIL nr14_first_round_rk_idx: got %0d want 13", rk_idx_b); end
        cycles = 1;
        while (out_valid_b !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        total += 2;
        if (cycles !== 15) begin bad++; $display("[TB] FAIL nr14_latency: got %0d want 15", cycles); end
        if (pt_b !== PT) begin bad++; $display("[TB] FAIL nr14_pt: got %h want %h", pt_b, PT); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_valid_b = 1'b0;
        out_ready = 1'b0;
        ct = '0;
        expand_key(KEY128, 4, 10);
        for (int r = 0; r < 16; r++) begin
            ks128[r] = (r <= 10) ? {words[4 * r], words[4 * r + 1], words[4 * r + 2], words[4 * r + 3]} : '0;
        end
        expand_key(KEY256, 8, 14);
        for (int r = 0; r < 16; r++) begin
            ks256[r] = (r <= 14) ? {words[4 * r], words[4 * r + 1], words[4 * r + 2], words[4 * r + 3]} : '0;
        end
        $display("[TB] starting aes_inv_cipher_ctrl directed tests");
        test_reset();
        test_fips128();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_nr14();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
Name: aes_inv_cipher_ctrl

Overview:
Iterative AES inverse-cipher sequencer. It owns the 128-bit state register, the round counter and the round-key index. Each clock it drives one decryption round through a combinational inverse-round datapath: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns on all rounds except the last. It sits between a ciphertext source and a plaintext sink, using valid/ready on both sides. Round keys come from an external expanded-key store, addressed by rk_idx.

Parameters:
NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); key store supplies matching keys.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  synchronous abort of the block in flight
in_valid  input  1  ciphertext valid
in_ready  output  1  block can accept ciphertext this cycle
ct  input  128  ciphertext; FIPS byte 0 in [127:120]
rk_idx  output  4  round-key index requested this cycle
rk  input  128  round key for rk_idx, combinationally valid same cycle
out_valid  output  1  plaintext valid
out_ready  input  1  sink accepts plaintext
pt  output  128  plaintext, same byte order as ct
busy  output  1  high in ROUND state

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous, active-high.
- Reset values: state=IDLE, round counter=0, state_reg=0. Outputs: in_ready=1, out_valid=0, busy=0, rk_idx=NR, pt=0.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - rk_idx=NR; in_ready=1.
  - On in_valid: state_reg<=ct^rk, round<=NR-1, go to ROUND.
- ROUND:
  - rk_idx=round; busy=1; in_ready=0.
  - state_reg <= inv_round(state_reg, rk, last=(round==0)).
  - If round==0, go to DONE; else round<=round-1.
- DONE:
  - out_valid=1; pt=state_reg, held stable until accepted; rk_idx=NR.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=1 and in_valid=1: back-to-back accept. in_ready=out_ready combinationally in DONE. Load ct^rk, go to ROUND.
  - out_ready=0: stay in DONE; in_ready=0.
- Latency:
  - Accept edge E0, then NR ROUND edges.
  - out_valid rises after edge E0+NR: 11 cycles from accept cycle to first out_valid cycle for NR=10.
  - Throughput with out_ready tied high: one block per NR+1 cycles.
- pt is driven from state_reg at all times. It is meaningful only while out_valid=1.
- flush: in any state, next state=IDLE, round<=0. state_reg is not cleared. out_valid drops the next cycle.
- Priority: rst over flush over normal transitions. flush and in_valid in the same IDLE cycle: flush wins, nothing is accepted.
- Arithmetic:
  - Round counter is 4 bits and down-counts.
  - It never wraps: the round==0 check happens before decrement.
  - AddRoundKey is a bitwise 128-bit XOR.
  - InvMixColumns uses GF(2^8) with polynomial 0x11B.
- in_ready and out_valid are never both asserted except in DONE with out_ready=1.

Decomposition:
- Package aes_pkg:
  - FSM state enum.
  - NR_AES128/192/256 constants.
  - Inverse S-box function.
  - xtime/gmul helpers for coefficients 9, 11, 13, 14.
- Sub-module aes_inv_round, combinational:
  - Ports: state_in, rk, last, state_out.
  - Instantiates the existing invShiftRows, then 16 inverse S-box lookups, the key XOR, and InvMixColumns bypassed when last=1.
- Controller contains only the FSM, counter and state register.

Test Plan:
- FIPS-197 C.1, NR=10: key store loaded with expansion of key 000102030405060708090a0b0c0d0e0f; ct=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: state_reg after accept = 7ad5fda789ef4e272bca100b3d9ff59f.
  - Required: rk_idx sequence 10,9,…,0.
  - Required: out_valid 11 cycles after accept with pt=00112233445566778899aabbccddeeff.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Required: pt stable, in_ready=0, busy=0.
  - Then out_ready=1 for one cycle: out_valid=0 the next cycle, in_ready=1.
- Back-to-back: in_valid held high with the same ct, out_ready tied 1.
  - Required: second accept in the DONE cycle; pt valid every 11 cycles; no idle cycle between blocks.
- flush at the 5th ROUND cycle.
  - Required: next cycle state=IDLE, in_ready=1, out_valid never asserted.
  - Required: a following new block decrypts correctly.
- rst asserted mid-ROUND and in DONE.
  - Required: next cycle all outputs at reset values (out_valid=0, busy=0, rk_idx=10, in_ready=1).
- NR=14, FIPS-197 C.3 key 000102…1f, ct=8ea2b7ca516745bfeafc49904b496089.
  - Required: pt=00112233445566778899aabbccddeeff after 15 cycles; rk_idx starts at 14.
